hazard_controller: RTL and testbench

Central hazard and sequencing controller for the 5-stage pipelined core.
- Generates forwarding selects for the Execute-stage operands.
- Generates stall and flush controls for load-use hazards and taken branches/jumps.
- Sequences the multi-cycle MUL/DIV unit in Execute: launches it, holds F/D/E while it runs, and inserts bubbles into Memory until the result is captured.

---
 rtl/hazard_pkg.sv | 41 ++++
 rtl/md_sequencer.sv | 75 +++++++
 rtl/hazard_controller.sv | 124 ++++++++++++
 tb/tb_hazard_controller.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard controller and MUL/DIV sequencer.
//   fwd_sel_t   : Execute operand forwarding select
//   md_state_t  : MUL/DIV sequencer state
//   fwd_select(): forwarding priority (Memory beats Writeback, x0 never forwards)
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_DONE = 2'b10
    } md_state_t;

    localparam logic [1:0]  RESULT_SRC_LOAD = 2'b01;
    localparam int unsigned MD_CNT_W        = 4;

    function automatic fwd_sel_t fwd_select(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (rs != 5'd0) begin
            if (we_m && (rd_m == rs)) begin
                sel = FWD_MEM;
            end else if (we_w && (rd_w == rs)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/md_sequencer.sv
// MUL/DIV launch sequencer. Pulses go_o when a MUL/DIV arrives in Execute while idle,
// counts down the unit latency, then raises capture_o for one cycle.
// Ports:
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   start_i, is_div_i  : Execute holds a MUL/DIV; selects DIV latency
//   go_o               : one-cycle start pulse to the unit
//   capture_o          : result valid this cycle
//   hold_o             : hold F/D/E and bubble into M while the unit runs
module md_sequencer
    import hazard_pkg::*;
#(
    parameter int unsigned MulLat = 3,
    parameter int unsigned DivLat = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic is_div_i,
    output logic go_o,
    output logic capture_o,
    output logic hold_o
);

    // Launch cycle plus the DONE cycle account for two of the latency cycles.
    localparam logic [MD_CNT_W-1:0] MulCnt = MD_CNT_W'(MulLat - 2);
    localparam logic [MD_CNT_W-1:0] DivCnt = MD_CNT_W'(DivLat - 2);

    md_state_t             state_q, state_d;
    logic [MD_CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        go_o      = 1'b0;
        capture_o = 1'b0;
        hold_o    = 1'b0;
        unique case (state_q)
            MD_IDLE: begin
                if (start_i) begin
                    go_o    = 1'b1;
                    hold_o  = 1'b1;
                    cnt_d   = is_div_i ? DivCnt : MulCnt;
                    state_d = MD_RUN;
                end
            end
            MD_RUN: begin
                hold_o = 1'b1;
                if (cnt_q == '0) begin
                    state_d = MD_DONE;
                end else begin
                    cnt_d = cnt_q - MD_CNT_W'(1);
                end
            end
            MD_DONE: begin
                // Release the hold so the instruction advances to M at the next edge.
                capture_o = 1'b1;
                state_d   = MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for the 5-stage core: Execute forwarding selects,
// load-use stall, branch flush, and MUL/DIV hold merged with priority.
// Ports:
//   clk, reset (sync, active-low)
//   Rs1_D/Rs2_D, Rs1_E/Rs2_E/Rd_E, Rd_M/Rd_W, RegWrite_M/W, ResultSrc_E, PCSrc_E,
//   MdStart_E, MdIsDiv_E                    : pipeline status inputs
//   ForwardA_E/ForwardB_E                   : operand selects
//   Stall_F/D/E, Flush_D/E/M                : pipeline register controls
//   MdGo, MdCapture                         : MUL/DIV unit handshake
// Optional: define HAZARD_PERF_CNT_EN to add saturating StallCycles and FlushCount outputs.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned DIV_LAT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs1_D,
    input  logic [4:0] Rs2_D,
    input  logic [4:0] Rs1_E,
    input  logic [4:0] Rs2_E,
    input  logic [4:0] Rd_E,
    input  logic [4:0] Rd_M,
    input  logic [4:0] Rd_W,
    input  logic       RegWrite_M,
    input  logic       RegWrite_W,
    input  logic [1:0] ResultSrc_E,
    input  logic       PCSrc_E,
    input  logic       MdStart_E,
    input  logic       MdIsDiv_E,
    output logic [1:0] ForwardA_E,
    output logic [1:0] ForwardB_E,
    output logic       Stall_F,
    output logic       Stall_D,
    output logic       Stall_E,
    output logic       Flush_D,
    output logic       Flush_E,
    output logic       Flush_M,
    output logic       MdGo,
    output logic       MdCapture
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCount
`endif
);

    logic md_go, md_capture, md_hold;
    logic lw_stall;

    md_sequencer #(
        .MulLat (MUL_LAT),
        .DivLat (DIV_LAT)
    ) u_md_sequencer (
        .clk_i     (clk),
        .rst_ni    (reset),
        .start_i   (MdStart_E),
        .is_div_i  (MdIsDiv_E),
        .go_o      (md_go),
        .capture_o (md_capture),
        .hold_o    (md_hold)
    );

    assign lw_stall = (ResultSrc_E == RESULT_SRC_LOAD) && (Rd_E != 5'd0) &&
                      ((Rs1_D == Rd_E) || (Rs2_D == Rd_E));

    // Everything is forced quiet while reset is held low.
    always_comb begin
        ForwardA_E = FWD_RF;
        ForwardB_E = FWD_RF;
        Stall_F    = 1'b0;
        Stall_D    = 1'b0;
        Stall_E    = 1'b0;
        Flush_D    = 1'b0;
        Flush_E    = 1'b0;
        Flush_M    = 1'b0;
        MdGo       = 1'b0;
        MdCapture  = 1'b0;
        if (reset) begin
            ForwardA_E = fwd_select(Rs1_E, Rd_M, RegWrite_M, Rd_W, RegWrite_W);
            ForwardB_E = fwd_select(Rs2_E, Rd_M, RegWrite_M, Rd_W, RegWrite_W);
            // MUL/DIV hold overrides load-use and branch flushes.
            Stall_F    = md_hold | lw_stall;
            Stall_D    = md_hold | lw_stall;
            Stall_E    = md_hold;
            Flush_M    = md_hold;
            Flush_D    = PCSrc_E & ~md_hold;
            Flush_E    = (lw_stall | PCSrc_E) & ~md_hold;
            MdGo       = md_go;
            MdCapture  = md_capture;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (Stall_D && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if ((Flush_D || Flush_E) && (flush_count_q != 32'hFFFF_FFFF)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign StallCycles = stall_cycles_q;
    assign FlushCount  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller (MUL_LAT=3, DIV_LAT=8).
// ctl vector order: {Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M, MdGo, MdCapture}
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
    logic       RegWrite_M, RegWrite_W;
    logic [1:0] ResultSrc_E;
    logic       PCSrc_E, MdStart_E, MdIsDiv_E;
    logic [1:0] ForwardA_E, ForwardB_E;
    logic       Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M, MdGo, MdCapture;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] StallCycles, FlushCount;
`endif

    logic [7:0] ctl;
    assign ctl = {Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M, MdGo, MdCapture};

    int n_chk  = 0;
    int n_fail = 0;

    hazard_controller #(
        .MUL_LAT (3),
        .DIV_LAT (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Rs1_D       (Rs1_D),
        .Rs2_D       (Rs2_D),
        .Rs1_E       (Rs1_E),
        .Rs2_E       (Rs2_E),
        .Rd_E        (Rd_E),
        .Rd_M        (Rd_M),
        .Rd_W        (Rd_W),
        .RegWrite_M  (RegWrite_M),
        .RegWrite_W  (RegWrite_W),
        .ResultSrc_E (ResultSrc_E),
        .PCSrc_E     (PCSrc_E),
        .MdStart_E   (MdStart_E),
        .MdIsDiv_E   (MdIsDiv_E),
        .ForwardA_E  (ForwardA_E),
        .ForwardB_E  (ForwardB_E),
        .Stall_F     (Stall_F),
        .Stall_D     (Stall_D),
        .Stall_E     (Stall_E),
        .Flush_D     (Flush_D),
        .Flush_E     (Flush_E),
        .Flush_M     (Flush_M),
        .MdGo        (MdGo),
        .MdCapture   (MdCapture)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .StallCycles (StallCycles),
        .FlushCount  (FlushCount)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where new inputs are applied.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0; Rd_E = 0; Rd_M = 0; Rd_W = 0;
        RegWrite_M = 0; RegWrite_W = 0; ResultSrc_E = 2'b00; PCSrc_E = 0;
        MdStart_E = 0; MdIsDiv_E = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        clr_inputs();
        cyc();
        cyc();
        // Reset: every hazard condition asserted but outputs must stay quiet.
        Rs1_E = 5; Rd_M = 5; RegWrite_M = 1; ResultSrc_E = 2'b01; Rd_E = 7; Rs2_D = 7;
        PCSrc_E = 1; MdStart_E = 1;
        #1;
        chk("rst_ctl", {24'd0, ctl}, 32'h00);
        chk("rst_fwd", {28'd0, ForwardA_E, ForwardB_E}, 32'h0);
`ifdef HAZARD_PERF_CNT_EN
        chk("rst_stallcnt", StallCycles, 32'd0);
        chk("rst_flushcnt", FlushCount, 32'd0);
`endif
        cyc();
        clr_inputs();
        reset = 1'b1;
        #1;
        chk("idle_ctl", {24'd0, ctl}, 32'h00);

        // Forwarding
        Rs1_E = 5; Rs2_E = 5; Rd_M = 5; RegWrite_M = 1; Rd_W = 5; RegWrite_W = 1;
        #1;
        chk("fwdA_mem", {30'd0, ForwardA_E}, 32'd2);
        chk("fwdB_mem", {30'd0, ForwardB_E}, 32'd2);
        RegWrite_M = 0;
        #1;
        chk("fwdA_wb", {30'd0, ForwardA_E}, 32'd1);
        chk("fwdB_wb", {30'd0, ForwardB_E}, 32'd1);
        Rs1_E = 0; Rd_M = 0; Rd_W = 0; RegWrite_M = 1;
        #1;
        chk("fwdA_x0", {30'd0, ForwardA_E}, 32'd0);
        Rs1_E = 9; Rs2_E = 3; Rd_M = 9; Rd_W = 3; RegWrite_M = 1; RegWrite_W = 1;
        #1;
        chk("fwdA_mem2", {30'd0, ForwardA_E}, 32'd2);
        chk("fwdB_wb2", {30'd0, ForwardB_E}, 32'd1);
        RegWrite_W = 0;
        #1;
        chk("fwdB_rf", {30'd0, ForwardB_E}, 32'd0);

        // Load-use
        cyc();
        clr_inputs();
        ResultSrc_E = 2'b01; Rd_E = 7; Rs2_D = 7;
        #1;
        chk("lw_rs2", {24'd0, ctl}, 32'hC8);
        cyc();
        clr_inputs();
        #1;
        chk("lw_after", {24'd0, ctl}, 32'h00);
        ResultSrc_E = 2'b01; Rd_E = 0; Rs1_D = 0; Rs2_D = 0;
        #1;
        chk("lw_x0", {24'd0, ctl}, 32'h00);
        ResultSrc_E = 2'b00; Rd_E = 4; Rs1_D = 4;
        #1;
        chk("lw_notload", {24'd0, ctl}, 32'h00);

        // Branch
        cyc();
        clr_inputs();
        PCSrc_E = 1;
        #1;
        chk("branch", {24'd0, ctl}, 32'h18);
        cyc();
        clr_inputs();
        #1;
        chk("branch_after", {24'd0, ctl}, 32'h00);

        // MUL, LAT=3
        cyc();
        MdStart_E = 1; MdIsDiv_E = 0;
        #1;
        chk("mul_t0", {24'd0, ctl}, 32'hE6);
        cyc();
        ResultSrc_E = 2'b01; Rd_E = 6; Rs1_D = 6;  // load-use must not add Flush_E
        #1;
        chk("mul_t1", {24'd0, ctl}, 32'hE4);
        ResultSrc_E = 2'b00; Rd_E = 0; Rs1_D = 0;
        cyc();
        #1;
        chk("mul_t2", {24'd0, ctl}, 32'hE4);
        cyc();
        #1;
        chk("mul_t3", {24'd0, ctl}, 32'h01);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall", StallCycles, 32'd4);
        chk("perf_flush", FlushCount, 32'd2);
`endif
        cyc();
        MdStart_E = 0;
        #1;
        chk("mul_t4", {24'd0, ctl}, 32'h00);

        // DIV (LAT=8) immediately followed by MUL
        cyc();
        MdStart_E = 1; MdIsDiv_E = 1;
        #1;
        chk("div_t0", {24'd0, ctl}, 32'hE6);
        for (int k = 1; k < 8; k++) begin
            cyc();
            #1;
            chk($sformatf("div_t%0d", k), {24'd0, ctl}, 32'hE4);
        end
        cyc();
        #1;
        chk("div_t8", {24'd0, ctl}, 32'h01);
        cyc();
        MdIsDiv_E = 0;
        #1;
        chk("mul2_t9", {24'd0, ctl}, 32'hE6);
        cyc();
        #1;
        chk("mul2_t10", {24'd0, ctl}, 32'hE4);
        cyc();
        #1;
        chk("mul2_t11", {24'd0, ctl}, 32'hE4);
        cyc();
        #1;
        chk("mul2_t12", {24'd0, ctl}, 32'h01);
        cyc();
        MdStart_E = 0;
        #1;
        chk("mul2_t13", {24'd0, ctl}, 32'h00);

        // Reset during DIV RUN
        cyc();
        MdStart_E = 1; MdIsDiv_E = 1;
        #1;
        chk("rdiv_t0", {24'd0, ctl}, 32'hE6);
        cyc();
        #1;
        chk("rdiv_t1", {24'd0, ctl}, 32'hE4);
        cyc();
        reset = 1'b0;
        #1;
        chk("rdiv_t2_rst", {24'd0, ctl}, 32'h00);
        cyc();
        reset = 1'b1;
        MdStart_E = 0; MdIsDiv_E = 0;
        #1;
`ifdef HAZARD_PERF_CNT_EN
        chk("rdiv_stallcnt", StallCycles, 32'd0);
        chk("rdiv_flushcnt", FlushCount, 32'd0);
`endif
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("rdiv_quiet%0d", k), {24'd0, ctl}, 32'h00);
            cyc();
        end
        // Only IDLE launches immediately.
        MdStart_E = 1;
        #1;
        chk("post_rst_go", {24'd0, ctl}, 32'hE6);
        cyc();
        cyc();
        cyc();
        #1;
        chk("post_rst_cap", {24'd0, ctl}, 32'h01);
`ifdef HAZARD_PERF_CNT_EN
        chk("post_rst_stallcnt", StallCycles, 32'd3);
`endif
        cyc();
        MdStart_E = 0;
        #1;
        chk("final_idle", {24'd0, ctl}, 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
